// File: rtl/act_out_buffer_pkg.sv
// +----------------------------------------------------------------------------+
// | act_out_buffer_pkg                                                          |
// | Shared constants and FILL/DRAIN state encoding for the activation buffer.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package act_out_buffer_pkg;

  localparam int AOB_D_LEN   = 32;
  localparam int AOB_ACT_LAT = 2;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } aob_state_t;

endpackage : act_out_buffer_pkg

`default_nettype wire

// File: rtl/act_out_buffer_if.sv
// +----------------------------------------------------------------------------+
// | act_out_buffer_if                                                           |
// | Activation result input plus valid/ready output stream of the buffer.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface act_out_buffer_if #(
  parameter int D_LEN = 32,
  parameter int IDX_W = 4
);

  logic             in_valid;
  logic [D_LEN-1:0] act_data;
  logic [D_LEN-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;

  // master: the buffer itself; slave: the surrounding layer logic
  modport master (
    input  in_valid, act_data, out_ready,
    output out_data, out_valid, out_last, out_idx
  );

  modport slave (
    output in_valid, act_data, out_ready,
    input  out_data, out_valid, out_last, out_idx
  );

endinterface : act_out_buffer_if

`default_nettype wire

// File: rtl/act_out_buffer_vld_delay.sv
// +----------------------------------------------------------------------------+
// | act_out_buffer_vld_delay                                                    |
// | DEPTH-cycle valid strobe delay line, reusable for fixed-latency stages.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module act_out_buffer_vld_delay #(
  parameter int DEPTH = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic vld_in,
  output logic      vld_out
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        pipe_d = clr ? 1'b0 : vld_in;
      end
    end else begin : g_shift
      always_comb begin
        pipe_d = clr ? '0 : {pipe_q[DEPTH-2:0], vld_in};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign vld_out = pipe_q[DEPTH-1];

endmodule : act_out_buffer_vld_delay

`default_nettype wire

// File: rtl/act_out_buffer.sv
// +----------------------------------------------------------------------------+
// | act_out_buffer                                                              |
// | Collects N_NEURON activation results, then streams them out valid/ready.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module act_out_buffer
  import act_out_buffer_pkg::*;
#(
  parameter int D_LEN    = AOB_D_LEN,
  parameter int N_NEURON = 16,
  parameter int ACT_LAT  = AOB_ACT_LAT,
  parameter int IDX_W    = $clog2(N_NEURON)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr,
  act_out_buffer_if.master   bus,
  output logic               busy,
  output logic               layer_done,
  output logic               ovf_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);

  aob_state_t       state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             layer_done_q, layer_done_d;
  logic             ovf_err_q, ovf_err_d;
  logic             buf_we;
  logic             cap;
  logic [D_LEN-1:0] buf_q [N_NEURON];

  act_out_buffer_vld_delay #(
    .DEPTH (ACT_LAT)
  ) u_vld_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .vld_in  (bus.in_valid),
    .vld_out (cap)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ovf_err_d    = ovf_err_q;
    layer_done_d = 1'b0;
    buf_we       = 1'b0;
    if (clr) begin
      state_d   = ST_FILL;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ovf_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (cap) begin
            buf_we = 1'b1;
            if (wr_ptr_q == LAST_IDX) begin
              wr_ptr_d = '0;
              state_d  = ST_DRAIN;
            end else begin
              wr_ptr_d = wr_ptr_q + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // The upstream was told to stall; a result now has nowhere to go.
          if (cap) begin
            ovf_err_d = 1'b1;
          end
          if (bus.out_ready) begin
            if (rd_ptr_q == LAST_IDX) begin
              rd_ptr_d     = '0;
              state_d      = ST_FILL;
              layer_done_d = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + IDX_W'(1);
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      layer_done_q <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      layer_done_q <= layer_done_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // Storage is deliberately left out of reset; contents are only observed in DRAIN.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_ptr_q] <= bus.act_data;
    end
  end

  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.out_data  = buf_q[rd_ptr_q];
  assign bus.out_idx   = rd_ptr_q;
  assign bus.out_last  = (state_q == ST_DRAIN) && (rd_ptr_q == LAST_IDX);
  assign busy          = (state_q == ST_DRAIN);
  assign layer_done    = layer_done_q;
  assign ovf_err       = ovf_err_q;

endmodule : act_out_buffer

`default_nettype wire

// File: tb/tb_act_out_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_act_out_buffer                                                           |
// | Directed scoreboard bench for act_out_buffer with N_NEURON=4, ACT_LAT=2.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_act_out_buffer;

  localparam int D_LEN    = 32;
  localparam int N_NEURON = 4;
  localparam int ACT_LAT  = 2;
  localparam int IDX_W    = 2;

  typedef struct packed {
    logic [D_LEN-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  logic clk;
  logic rst;
  logic clr;
  logic busy;
  logic layer_done;
  logic ovf_err;

  int   checks;
  int   failures;
  exp_t exp_q[$];

  act_out_buffer_if #(.D_LEN(D_LEN), .IDX_W(IDX_W)) sif ();

  act_out_buffer #(
    .D_LEN    (D_LEN),
    .N_NEURON (N_NEURON),
    .ACT_LAT  (ACT_LAT),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .bus        (sif.master),
    .busy       (busy),
    .layer_done (layer_done),
    .ovf_err    (ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    exp_q.push_back('{data: w0, idx: 2'd0, last: 1'b0});
    exp_q.push_back('{data: w1, idx: 2'd1, last: 1'b0});
    exp_q.push_back('{data: w2, idx: 2'd2, last: 1'b0});
    exp_q.push_back('{data: w3, idx: 2'd3, last: 1'b1});
  endtask

  // Scoreboard monitor: every accepted word must match the next expected entry.
  always @(negedge clk) begin
    if (sif.out_valid && sif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got data %h idx %0d, expected no word", sif.out_data, sif.out_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", sif.out_data, e.data);
        chk("sb_idx", 32'(sif.out_idx), 32'(e.idx));
        chk("sb_last", 32'(sif.out_last), 32'(e.last));
      end
    end
  end

  // Fill 4 words via in_valid on cycles 0-3, drain with ready high; checks timing.
  task automatic run_basic(input string tag);
    logic [31:0] w [4];
    w[0] = 32'h3F800000; w[1] = 32'h40000000; w[2] = 32'h40400000; w[3] = 32'h40800000;
    push_words(w[0], w[1], w[2], w[3]);
    for (int c = 0; c < 13; c++) begin
      sif.in_valid  = (c < 4);
      sif.act_data  = (c >= 2 && c <= 5) ? w[c-2] : (32'hBAD00000 | 32'(c));
      sif.out_ready = 1'b1;
      @(negedge clk);
      if (c == 5 || c == 6) chk({tag, "_valid_start"}, 32'(sif.out_valid), 32'(c == 6));
      if (c == 6) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (c == 9) chk({tag, "_last"}, 32'(sif.out_last), 32'd1);
      chk({tag, "_layer_done"}, 32'(layer_done), 32'(c == 10));
      next_cycle();
    end
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] t3 [4];
    logic [31:0] w4 [4];
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    clr = 1'b0;
    sif.in_valid  = 1'b0;
    sif.act_data  = '0;
    sif.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_last", 32'(sif.out_last), 32'd0);
    chk("rst_layer_done", 32'(layer_done), 32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    chk("rst_out_idx", 32'(sif.out_idx), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Basic fill and drain
    run_basic("t1");

    // Backpressure: ready low for 5 cycles at the start of DRAIN
    push_words(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    w4[0] = 32'h3F800000; w4[1] = 32'h40000000; w4[2] = 32'h40400000; w4[3] = 32'h40800000;
    for (int c = 0; c < 17; c++) begin
      sif.in_valid  = (c < 4);
      sif.act_data  = (c >= 2 && c <= 5) ? w4[c-2] : (32'hBAD10000 | 32'(c));
      sif.out_ready = !(c >= 6 && c <= 10);
      @(negedge clk);
      if (c >= 6 && c <= 10) begin
        chk("t2_hold_data", sif.out_data, 32'h3F800000);
        chk("t2_hold_idx", 32'(sif.out_idx), 32'd0);
      end
      chk("t2_layer_done", 32'(layer_done), 32'(c == 15));
      next_cycle();
    end
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Latency alignment: pulses at 0,3,4,9 capture at 2,5,6,11
    t3[0] = 32'h11110000; t3[1] = 32'h22220000; t3[2] = 32'h33330000; t3[3] = 32'h44440000;
    push_words(t3[0], t3[1], t3[2], t3[3]);
    for (int c = 0; c < 18; c++) begin
      sif.in_valid  = (c == 0 || c == 3 || c == 4 || c == 9);
      sif.act_data  = (c == 2)  ? t3[0] :
                      (c == 5)  ? t3[1] :
                      (c == 6)  ? t3[2] :
                      (c == 11) ? t3[3] : (32'hBAD20000 | 32'(c));
      sif.out_ready = 1'b1;
      @(negedge clk);
      if (c == 11 || c == 12) chk("t3_drain_entry", 32'(sif.out_valid), 32'(c == 12));
      chk("t3_layer_done", 32'(layer_done), 32'(c == 16));
      next_cycle();
    end
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: extra capture during DRAIN is dropped and flagged
    w4[0] = 32'hA0000001; w4[1] = 32'hA0000002; w4[2] = 32'hA0000003; w4[3] = 32'hA0000004;
    push_words(w4[0], w4[1], w4[2], w4[3]);
    for (int c = 0; c < 17; c++) begin
      sif.in_valid  = (c < 4) || (c == 6);
      sif.act_data  = (c >= 2 && c <= 5) ? w4[c-2] : (c == 8) ? 32'hDEADBEEF : (32'hBAD30000 | 32'(c));
      sif.out_ready = (c >= 10);
      @(negedge clk);
      chk("t4_ovf_err", 32'(ovf_err), 32'(c >= 9));
      next_cycle();
    end
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    sif.in_valid = 1'b0;
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
    @(negedge clk);
    chk("t4_ovf_cleared", 32'(ovf_err), 32'd0);
    next_cycle();

    // clr mid-fill: 2 captures, clr discards an in-flight third, then a fresh layer
    push_words(32'h1, 32'h2, 32'h3, 32'h4);
    for (int c = 0; c < 17; c++) begin
      sif.in_valid  = (c < 3) || (c >= 5 && c <= 8);
      clr           = (c == 4);
      sif.act_data  = (c >= 2 && c <= 4)  ? (32'hAAAA0000 | 32'(c)) :
                      (c >= 7 && c <= 10) ? 32'(c - 6) : (32'hBAD40000 | 32'(c));
      sif.out_ready = 1'b1;
      @(negedge clk);
      if (c == 10 || c == 11) chk("t5_drain_entry", 32'(sif.out_valid), 32'(c == 11));
      chk("t5_layer_done", 32'(layer_done), 32'(c == 15));
      next_cycle();
    end
    clr = 1'b0;
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Async reset mid-drain after words 0 and 1 have been accepted
    push_words(32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004);
    for (int c = 0; c < 8; c++) begin
      sif.in_valid  = (c < 4);
      sif.act_data  = (c >= 2 && c <= 5) ? (32'hC0000000 | 32'(c - 1)) : (32'hBAD50000 | 32'(c));
      sif.out_ready = 1'b1;
      next_cycle();
    end
    sif.out_ready = 1'b0;
    @(negedge clk);
    chk("t6_pre_rst_valid", 32'(sif.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(sif.out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_last", 32'(sif.out_last), 32'd0);
    chk("t6_rst_idx", 32'(sif.out_idx), 32'd0);
    chk("t6_consumed", 32'(N_NEURON - exp_q.size()), 32'd2);
    exp_q.delete();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    run_basic("t6_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_act_out_buffer

`default_nettype wire
